// File: rtl/mem_obi_pkg.sv
// Shared types and helpers for the OBI-to-memory bridge: response entry layout,
// wait-state LFSR taps and the modulo helper that picks a random wait count.
package mem_obi_pkg;

  localparam int          MEM_OBI_DW    = 32;
  localparam int          RSP_DEPTH_DEF = 4;
  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  typedef struct packed {
    logic [MEM_OBI_DW-1:0] rdata;
    logic                  err;
    logic [3:0]            info;
  } resp_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] wait_pick(input logic [15:0] state, input logic [3:0] wmax);
    logic [15:0] rem;
    rem = state % ({12'd0, wmax} + 16'd1);
    return rem[3:0];
  endfunction

endpackage

// File: rtl/mem_obi_rsp_fifo.sv
// In-order response FIFO; a push into a full FIFO is accepted only alongside a pop.
module mem_obi_rsp_fifo
  import mem_obi_pkg::*;
#(
  parameter int DEPTH = RSP_DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  resp_t                      push_data,
  input  logic                       pop,
  output resp_t                      head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  resp_t         mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_obi_intf.sv
// OBI request channel to 1-cycle-read synchronous memory with LFSR-driven grant and
// response wait states. Define MEM_OBI_ERR_EN to forward mem_err onto data_err.
module mem_obi_intf
  import mem_obi_pkg::*;
#(
  parameter int          DW        = MEM_OBI_DW,
  parameter int          RSP_DEPTH = RSP_DEPTH_DEF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [3:0]    GNT_WMAX,
  input  logic [3:0]    RESP_WMAX,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [3:0]    data_be,
  input  logic          data_is_cap,
  input  logic [31:0]   data_addr,
  input  logic [DW-1:0] data_wdata,
  input  logic [7:0]    data_flag,
  output logic          data_gnt,
  output logic          data_rvalid,
  output logic [DW-1:0] data_rdata,
  output logic          data_err,
  output logic [3:0]    data_resp_info,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [7:0]    mem_flag,
  output logic [29:0]   mem_addr32,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_err
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic [15:0]   lfsr_r;
  logic          gnt_active_r, rsp_active_r;
  logic [3:0]    gnt_cnt_r, rsp_cnt_r;
  logic [3:0]    gnt_eff_s, rsp_eff_s;
  logic          gnt_s, rvalid_s, busy_s;
  logic          cap_valid_r, cap_we_r;
  logic [3:0]    cap_info_r;
  resp_t         push_entry_s, head_s, cand_s;
  logic          fifo_empty_s, fifo_full_s, push_s, pop_s, cand_valid_s;
  logic [CW-1:0] fifo_count_s, occ_s;

`ifdef MEM_OBI_ERR_EN
  logic [1:0] unused_s;
  assign unused_s = data_addr[1:0];
`else
  logic [2:0] unused_s;
  assign unused_s = {mem_err, data_addr[1:0]};
`endif

  // Occupancy counts the capture stage so a grant never overruns the FIFO
  assign occ_s     = fifo_count_s + CW'(cap_valid_r);
  assign busy_s    = (occ_s >= CW'(RSP_DEPTH));
  assign gnt_eff_s = gnt_active_r ? gnt_cnt_r : wait_pick(lfsr_r, GNT_WMAX);
  assign gnt_s     = ~rst_i & data_req & (gnt_eff_s == 4'd0) & ~busy_s;

  assign data_gnt   = gnt_s;
  assign mem_cs     = data_req & gnt_s;
  assign mem_we     = data_we;
  assign mem_be     = data_be;
  assign mem_flag   = data_flag;
  assign mem_addr32 = data_addr[31:2];
  assign mem_wdata  = data_wdata;

  // The captured entry bypasses an empty FIFO so rvalid can follow gnt by one cycle
  assign cand_valid_s = ~fifo_empty_s | cap_valid_r;
  assign cand_s       = fifo_empty_s ? push_entry_s : head_s;
  assign rsp_eff_s    = rsp_active_r ? rsp_cnt_r : wait_pick(lfsr_r, RESP_WMAX);
  assign rvalid_s     = ~rst_i & cand_valid_s & (rsp_eff_s == 4'd0);
  assign pop_s        = rvalid_s & ~fifo_empty_s;
  assign push_s       = cap_valid_r & ~(fifo_empty_s & rvalid_s);

  // Wait-state LFSR, free running
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_r <= LFSR_SEED;
    else       lfsr_r <= lfsr_next(lfsr_r);
  end

  // Grant wait counter: loaded on the first request cycle, cleared by grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_active_r <= 1'b0;
      gnt_cnt_r    <= 4'd0;
    end else if (data_req & ~gnt_s) begin
      gnt_active_r <= 1'b1;
      gnt_cnt_r    <= (gnt_eff_s == 4'd0) ? 4'd0 : gnt_eff_s - 4'd1;
    end else begin
      gnt_active_r <= 1'b0;
      gnt_cnt_r    <= 4'd0;
    end
  end

  // Capture stage: marks the cycle in which mem_rdata/mem_err are valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_valid_r <= 1'b0;
      cap_we_r    <= 1'b0;
      cap_info_r  <= 4'd0;
    end else begin
      cap_valid_r <= mem_cs;
      cap_we_r    <= data_we;
      cap_info_r  <= {data_flag[2:0], data_is_cap};
    end
  end

  // Response entry built from the memory read port
  always_comb begin
    push_entry_s      = '0;
    push_entry_s.info = cap_info_r;
`ifdef MEM_OBI_ERR_EN
    push_entry_s.err  = mem_err;
    if (cap_we_r | mem_err) push_entry_s.rdata = '0;
    else                    push_entry_s.rdata = mem_rdata;
`else
    push_entry_s.err  = 1'b0;
    if (cap_we_r) push_entry_s.rdata = '0;
    else          push_entry_s.rdata = mem_rdata;
`endif
  end

  // Response wait counter for the current head entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_active_r <= 1'b0;
      rsp_cnt_r    <= 4'd0;
    end else if (rvalid_s) begin
      rsp_active_r <= 1'b0;
      rsp_cnt_r    <= 4'd0;
    end else if (cand_valid_s) begin
      rsp_active_r <= 1'b1;
      rsp_cnt_r    <= rsp_eff_s - 4'd1;
    end else begin
      rsp_active_r <= rsp_active_r;
      rsp_cnt_r    <= rsp_cnt_r;
    end
  end

  // Response outputs are zero whenever rvalid is low
  always_comb begin
    data_rvalid    = rvalid_s;
    data_rdata     = '0;
    data_err       = 1'b0;
    data_resp_info = 4'd0;
    if (rvalid_s) begin
      data_rdata     = cand_s.rdata;
      data_err       = cand_s.err;
      data_resp_info = cand_s.info;
    end else begin
      data_rdata     = '0;
      data_err       = 1'b0;
      data_resp_info = 4'd0;
    end
  end

  mem_obi_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_count_s)
  );

  logic unused_full_s;
  assign unused_full_s = fifo_full_s;

endmodule

// File: tb/tb_mem_obi_intf.sv
// Directed self-checking bench for mem_obi_intf with a behavioural 1-cycle memory.
module tb_mem_obi_intf;

`ifdef MEM_OBI_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  info;
    int          gcyc;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  GNT_WMAX, RESP_WMAX;
  logic        data_req, data_we, data_is_cap;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic [7:0]  data_flag;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic [3:0]  data_resp_info;
  logic        mem_cs, mem_we;
  logic [3:0]  mem_be;
  logic [7:0]  mem_flag;
  logic [29:0] mem_addr32;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_err = 1'b0;

  logic [31:0] tbmem [0:255];
  logic        mem_load, err_on;
  logic [31:0] err_addr;

  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   mon_g = 0, mon_r = 0, last_rv = 0, rv_after_rst = 0;
  bit   bp_en = 1'b0, bp_full_seen = 1'b0, dly_en = 1'b0, rst_watch = 1'b0;
  exp_t exp_q[$];

  mem_obi_intf dut (
    .clk_i(clk_i), .rst_i(rst_i), .GNT_WMAX(GNT_WMAX), .RESP_WMAX(RESP_WMAX),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_is_cap(data_is_cap),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_flag(data_flag),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .data_err(data_err), .data_resp_info(data_resp_info),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be), .mem_flag(mem_flag),
    .mem_addr32(mem_addr32), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural memory: registered read, byte-enabled write, optional error on one address
  always @(posedge clk_i) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) tbmem[i] <= 32'hA000_0000 + i;
      tbmem[8'h40] <= 32'hDEADBEEF;
    end else if (mem_cs) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) tbmem[mem_addr32[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= tbmem[mem_addr32[7:0]];
      end
    end
    mem_err <= mem_cs & err_on & ~mem_we & ({mem_addr32, 2'b00} == err_addr);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Response monitor: in-order scoreboard, outstanding tracking, delay bounds
  initial begin
    exp_t e;
    int   pend, st;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        mon_g = 0;
        mon_r = 0;
      end else begin
        pend = mon_g - mon_r;
        if (bp_en) begin
          if (pend >= 4) begin
            bp_full_seen = 1'b1;
            check_eq("bp_gnt_low_when_full", data_gnt, 1'b0);
          end
          if (data_gnt) check_eq("bp_max_outstanding", (pend + 1 <= 4), 1'b1);
        end
        if (data_gnt) mon_g++;
        if (data_rvalid) begin
          mon_r++;
          if (rst_watch) rv_after_rst++;
          if (exp_q.size() == 0) begin
            check_eq("rv_unexpected", data_rvalid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check_eq("rv_rdata", data_rdata, e.rdata);
            check_eq("rv_err", data_err, e.err);
            check_eq("rv_info", data_resp_info, e.info);
            if (dly_en) begin
              st = (e.gcyc > last_rv) ? e.gcyc : last_rv;
              check_eq("rv_delay_1_to_8", (cyc - st >= 1) && (cyc - st <= 8), 1'b1);
            end
            last_rv = cyc;
          end
        end
      end
    end
  end

  task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [7:0] flag, input logic cap);
    data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
    data_be = be; data_flag = flag; data_is_cap = cap;
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic er, input logic [3:0] info);
    exp_t e;
    e.rdata = rd; e.err = er; e.info = info; e.gcyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [7:0] flag, input logic cap,
                       input logic [31:0] exp_rd, input logic exp_er, output int waits);
    set_req(we, addr, wdata, be, flag, cap);
    waits = 0;
    @(negedge clk_i);
    while (!data_gnt && waits < 80) begin
      waits++;
      @(negedge clk_i);
    end
    if (data_gnt) push_exp(exp_rd, exp_er, {flag[2:0], cap});
    else          check_eq("gnt_timeout", data_gnt, 1'b1);
    @(posedge clk_i); #1;
    data_req = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk_i);
      k++;
    end
    check_eq(tag, exp_q.size(), 0);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  w, rv_base, k;
    bit  reached;
    logic [31:0] er_rd;

    rst_i = 1'b1; mem_load = 1'b1; err_on = 1'b0; err_addr = 32'h0;
    GNT_WMAX = 4'd0; RESP_WMAX = 4'd0;
    set_req(1'b0, 32'h0, 32'h0, 4'hF, 8'h00, 1'b0);

    // Reset state, with a request already pending
    @(posedge clk_i); #1;
    mem_load = 1'b0;
    @(negedge clk_i);
    check_eq("rst_gnt", data_gnt, 1'b0);
    check_eq("rst_mem_cs", mem_cs, 1'b0);
    check_eq("rst_rvalid", data_rvalid, 1'b0);
    check_eq("rst_rdata", data_rdata, 32'h0);
    check_eq("rst_err", data_err, 1'b0);
    check_eq("rst_info", data_resp_info, 4'h0);
    @(posedge clk_i); #1;
    data_req = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Zero-wait read of 0x100
    set_req(1'b0, 32'h100, 32'h0, 4'hF, 8'h05, 1'b1);
    @(negedge clk_i);
    check_eq("zw_gnt_same_cycle", data_gnt, 1'b1);
    check_eq("zw_mem_cs", mem_cs, 1'b1);
    check_eq("zw_mem_addr32", mem_addr32, 30'h40);
    check_eq("zw_mem_we", mem_we, 1'b0);
    if (data_gnt) push_exp(32'hDEADBEEF, 1'b0, 4'hB);
    @(posedge clk_i); #1;
    data_req = 1'b0;
    @(negedge clk_i);
    check_eq("zw_rvalid_next", data_rvalid, 1'b1);
    check_eq("zw_rdata", data_rdata, 32'hDEADBEEF);
    @(negedge clk_i);
    check_eq("zw_rvalid_single", data_rvalid, 1'b0);
    wait_drain("zw_drain");

    // Write with partial byte enables
    set_req(1'b1, 32'h8, 32'h12345678, 4'b0011, 8'hA2, 1'b0);
    @(negedge clk_i);
    check_eq("wr_mem_cs", mem_cs, 1'b1);
    check_eq("wr_mem_we", mem_we, 1'b1);
    check_eq("wr_mem_be", mem_be, 4'b0011);
    check_eq("wr_mem_addr32", mem_addr32, 30'h2);
    check_eq("wr_mem_wdata", mem_wdata, 32'h12345678);
    check_eq("wr_mem_flag", mem_flag, 8'hA2);
    if (data_gnt) push_exp(32'h0, 1'b0, 4'h4);
    @(posedge clk_i); #1;
    data_req = 1'b0;
    @(negedge clk_i);
    check_eq("wr_rvalid", data_rvalid, 1'b1);
    check_eq("wr_rdata_zero", data_rdata, 32'h0);
    wait_drain("wr_drain");
    issue(1'b0, 32'h8, 32'h0, 4'hF, 8'h00, 1'b0, 32'hA0005678, 1'b0, w);
    check_eq("wr_readback_gnt_wait", w, 0);
    wait_drain("wr_readback_drain");

    // Back-to-back reads with random waits
    GNT_WMAX = 4'd7; RESP_WMAX = 4'd7;
    last_rv = 0; dly_en = 1'b1; rv_base = mon_r;
    for (int i = 0; i < 8; i++)
      issue(1'b0, 32'(4 * i), 32'h0, 4'hF, 8'(i), 1'b0,
            (i == 2) ? 32'hA0005678 : 32'hA000_0000 + 32'(i), 1'b0, w);
    wait_drain("b2b_drain");
    check_eq("b2b_rv_count", mon_r - rv_base, 8);
    dly_en = 1'b0;

    // Backpressure: long response waits, continuous requests
    GNT_WMAX = 4'd0; RESP_WMAX = 4'd15;
    bp_full_seen = 1'b0; bp_en = 1'b1;
    for (int i = 0; i < 24; i++)
      issue(1'b0, 32'(4 * (16 + i)), 32'h0, 4'hF, 8'h00, 1'b1, 32'hA000_0010 + 32'(i), 1'b0, w);
    wait_drain("bp_drain");
    bp_en = 1'b0;
    check_eq("bp_full_reached", bp_full_seen, 1'b1);

    // Memory error on the second of three reads
    GNT_WMAX = 4'd0; RESP_WMAX = 4'd0;
    err_on = 1'b1; err_addr = 32'h24;
    er_rd = ERR_EN ? 32'h0 : 32'hA000_0009;
    issue(1'b0, 32'h20, 32'h0, 4'hF, 8'h07, 1'b1, 32'hA000_0008, 1'b0, w);
    issue(1'b0, 32'h24, 32'h0, 4'hF, 8'h07, 1'b1, er_rd, ERR_EN, w);
    issue(1'b0, 32'h28, 32'h0, 4'hF, 8'h07, 1'b1, 32'hA000_000A, 1'b0, w);
    wait_drain("err_drain");
    err_on = 1'b0;

    // Reset with two responses outstanding
    GNT_WMAX = 4'd0; RESP_WMAX = 4'd15;
    k = 0; reached = 1'b0;
    set_req(1'b0, 32'(4 * 40), 32'h0, 4'hF, 8'h00, 1'b0);
    for (int c = 0; c < 40 && !reached; c++) begin
      @(negedge clk_i);
      if (data_gnt) begin
        push_exp(32'hA000_0028 + 32'(k), 1'b0, 4'h0);
        k++;
      end
      #1;
      if (mon_g - mon_r >= 2) reached = 1'b1;
      @(posedge clk_i); #1;
      data_addr = 32'(4 * (40 + k));
    end
    check_eq("rst_setup_two_outstanding", reached, 1'b1);
    rst_i = 1'b1; data_req = 1'b0;
    exp_q.delete();
    rv_after_rst = 0; rst_watch = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    check_eq("rst_no_rvalid_after", rv_after_rst, 0);
    rst_watch = 1'b0;
    GNT_WMAX = 4'd0; RESP_WMAX = 4'd0;
    issue(1'b0, 32'h100, 32'h0, 4'hF, 8'h05, 1'b1, 32'hDEADBEEF, 1'b0, w);
    check_eq("post_rst_gnt_wait", w, 0);
    @(negedge clk_i);
    check_eq("post_rst_rvalid", data_rvalid, 1'b1);
    check_eq("post_rst_rdata", data_rdata, 32'hDEADBEEF);
    wait_drain("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
